// File: rtl/switch_pkg.sv
// Shared types for the switch ingress path.
// port_id_t   : 2-bit output-port tag carried in the low bits of every FIFO word.
// wr_state_t  : states of the ingress writer FSM.
// PORT_NONE marks a header with no valid destination. Such a packet is dropped.
package switch_pkg;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT_NONE = 2'b00;
    localparam port_id_t PORT_1    = 2'b01;
    localparam port_id_t PORT_2    = 2'b10;
    localparam port_id_t PORT_3    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } wr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for the ingress statistics.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, clears the count
//   inc      in   count one event this cycle
//   count    out  current count; it holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment on request unless already saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ingress_port_writer.sv
// Write side of one switch input FIFO. It accepts a framed stream made of a header beat
// followed by payload beats. It checks the destination in the header, then writes each
// payload beat to the FIFO as {payload, dest}. Packets with no destination, and packets
// aborted by a new header, are dropped. Packets longer than MAX_LEN are truncated.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   in_data       stream data; on a header beat, in_data[1:0] is the destination port
//   in_valid      beat valid
//   in_sop        the beat is a header
//   in_eop        the beat is the last one of its packet
//   in_ready      a beat transfers when in_valid & in_ready
//   fifo_full     the downstream FIFO is full
//   fifo_wrreq    FIFO write strobe, same cycle as the accepted payload beat
//   fifo_data     {in_data, dest}
//   pkt_cnt       packets forwarded in full
//   drop_cnt      packets dropped
//   trunc_cnt     packets truncated at MAX_LEN
//   busy          the FSM is inside a packet
module ingress_port_writer
    import switch_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              fifo_wrreq,
    output logic [DATA_W+1:0] fifo_data,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  trunc_cnt,
    output logic              busy
);

    localparam int                LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

    wr_state_t        state, next_state;
    port_id_t         dest, next_dest;
    logic [LEN_W-1:0] len, next_len;
    logic [LEN_W-1:0] len_plus1;
    logic             acc;
    logic             is_header;
    logic             inc_pkt, inc_drop, inc_trunc;

    assign len_plus1 = len + LEN_W'(1);
    assign acc       = in_valid & in_ready;
    assign fifo_data = {in_data, dest};
    assign busy      = (state != IDLE);

    // Handshake, write strobe and next-state decode. Any header beat goes through the
    // same evaluation, whether it arrives in IDLE, in DROP, or mid-packet in FWD.
    // If an abort and a bad-destination header happen in the same cycle, they
    // count as a single drop.
    always_comb begin
        next_state = state;
        next_dest  = dest;
        next_len   = len;
        fifo_wrreq = 1'b0;
        inc_pkt    = 1'b0;
        inc_drop   = 1'b0;
        inc_trunc  = 1'b0;
        is_header  = 1'b0;
        in_ready   = (state == FWD) ? !fifo_full : 1'b1;

        case (state)
            IDLE: begin
                if (acc && in_sop) begin
                    is_header = 1'b1;
                end
            end
            FWD: begin
                if (acc) begin
                    if (in_sop) begin
                        inc_drop  = 1'b1;
                        is_header = 1'b1;
                    end else begin
                        fifo_wrreq = 1'b1;
                        next_len   = len_plus1;
                        if (in_eop) begin
                            inc_pkt    = 1'b1;
                            next_state = IDLE;
                        end else if (len_plus1 == LEN_MAX) begin
                            inc_trunc  = 1'b1;
                            next_state = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (acc) begin
                    if (in_sop) begin
                        is_header = 1'b1;
                    end else if (in_eop) begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (is_header) begin
            next_dest = in_data[1:0];
            next_len  = '0;
            if (in_data[1:0] == PORT_NONE) begin
                inc_drop   = 1'b1;
                next_state = in_eop ? IDLE : DROP;
            end else begin
                next_state = in_eop ? IDLE : FWD;
            end
        end
    end

    // Packet-tracking state: FSM state, latched destination and payload length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dest  <= PORT_NONE;
            len   <= '0;
        end else begin
            state <= next_state;
            dest  <= next_dest;
            len   <= next_len;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_pkt),
        .count   (pkt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_drop),
        .count   (drop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_trunc_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_trunc),
        .count   (trunc_cnt)
    );

endmodule

// File: tb/tb_ingress_port_writer.sv
// Directed testbench for ingress_port_writer. MAX_LEN is set to 4 so that truncation is reachable.
module tb_ingress_port_writer;

    localparam int DATA_W  = 6;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 16;

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic              in_ready;
    logic              fifo_full;
    logic              fifo_wrreq;
    logic [DATA_W+1:0] fifo_data;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  trunc_cnt;
    logic              busy;

    int checkCount;
    int passCount;
    int failCount;
    int fullWriteCount;
    logic [7:0] wrLog[$];
    logic [7:0] expLog[$];

    ingress_port_writer #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .fifo_full  (fifo_full),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .trunc_cnt  (trunc_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every FIFO write at the clock edge where the FIFO would take it.
    always @(posedge clk) begin
        if (fifo_wrreq) begin
            wrLog.push_back(fifo_data);
            if (fifo_full) fullWriteCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one beat shortly after a rising edge and let the combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic sop, input logic eop,
                                 input logic [DATA_W-1:0] d, input logic full);
        in_valid  = v;
        in_sop    = sop;
        in_eop    = eop;
        in_data   = d;
        fifo_full = full;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount = 0;
        failCount = 0;
        fullWriteCount = 0;
        reset_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; fifo_full = 1'b0;
        tick(); tick();
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_wrreq", 32'(fifo_wrreq), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cnts", 32'(pkt_cnt | drop_cnt | trunc_cnt), 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: dest=10, payload 5,6,7.
        applyStimulus(1, 1, 0, 6'd2, 0);
        checkOutput("t1_hdr_wrreq", 32'(fifo_wrreq), 32'd0);
        tick();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        applyStimulus(1, 0, 0, 6'd5, 0);
        checkOutput("t1_b0_wrreq", 32'(fifo_wrreq), 32'd1);
        checkOutput("t1_b0_data", 32'(fifo_data), 32'h16);
        tick();
        applyStimulus(1, 0, 0, 6'd6, 0);
        checkOutput("t1_b1_data", 32'(fifo_data), 32'h1A);
        tick();
        applyStimulus(1, 0, 1, 6'd7, 0);
        checkOutput("t1_b2_data", 32'(fifo_data), 32'h1E);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        checkOutput("t1_idle", 32'(busy), 32'd0);
        expLog.push_back(8'h16); expLog.push_back(8'h1A); expLog.push_back(8'h1E);

        // Test 2: dest=00 (upper bits set), then 4 beats -> dropped.
        applyStimulus(1, 1, 0, 6'h3C, 0);
        checkOutput("t2_hdr_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        checkOutput("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, (i == 3), 6'(i + 1), 0);
            checkOutput("t2_ready", 32'(in_ready), 32'd1);
            checkOutput("t2_wrreq", 32'(fifo_wrreq), 32'd0);
            tick();
        end
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t2_idle", 32'(busy), 32'd0);
        checkOutput("t2_writes", 32'(wrLog.size()), 32'd3);

        // Test 3: dest=01 with backpressure before beat 2.
        applyStimulus(1, 1, 0, 6'd1, 0);
        tick();
        applyStimulus(1, 0, 0, 6'd9, 0);
        checkOutput("t3_b0_data", 32'(fifo_data), 32'h25);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 6'd10, 1);
            checkOutput("t3_stall_ready", 32'(in_ready), 32'd0);
            checkOutput("t3_stall_wrreq", 32'(fifo_wrreq), 32'd0);
            tick();
        end
        applyStimulus(1, 0, 0, 6'd10, 0);
        checkOutput("t3_b1_ready", 32'(in_ready), 32'd1);
        checkOutput("t3_b1_data", 32'(fifo_data), 32'h29);
        tick();
        applyStimulus(1, 0, 1, 6'd11, 0);
        checkOutput("t3_b2_data", 32'(fifo_data), 32'h2D);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);
        checkOutput("t3_writes", 32'(wrLog.size()), 32'd6);
        expLog.push_back(8'h25); expLog.push_back(8'h29); expLog.push_back(8'h2D);

        // Test 4: dest=11, 6 beats -> truncated after 4 words.
        applyStimulus(1, 1, 0, 6'd3, 0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 0, (i == 6), 6'(i), 0);
            checkOutput("t4_wrreq", 32'(fifo_wrreq), (i <= 4) ? 32'd1 : 32'd0);
            tick();
            if (i == 4) checkOutput("t4_trunc_busy", 32'(busy), 32'd1);
        end
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t4_trunc_cnt", 32'(trunc_cnt), 32'd1);
        checkOutput("t4_pkt_cnt", 32'(pkt_cnt), 32'd2);
        checkOutput("t4_idle", 32'(busy), 32'd0);
        expLog.push_back(8'h07); expLog.push_back(8'h0B);
        expLog.push_back(8'h0F); expLog.push_back(8'h13);

        // Header-only packet with a valid destination: nothing written, nothing counted.
        applyStimulus(1, 1, 1, 6'd1, 0);
        checkOutput("ho_wrreq", 32'(fifo_wrreq), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("ho_busy", 32'(busy), 32'd0);
        checkOutput("ho_cnts", 32'(pkt_cnt + drop_cnt + trunc_cnt), 32'd4);

        // Test 5: dest=01 with 2 beats, then aborted by a new header dest=10.
        applyStimulus(1, 1, 0, 6'd1, 0);
        tick();
        applyStimulus(1, 0, 0, 6'd20, 0);
        checkOutput("t5_b0_data", 32'(fifo_data), 32'h51);
        tick();
        applyStimulus(1, 0, 0, 6'd21, 0);
        checkOutput("t5_b1_data", 32'(fifo_data), 32'h55);
        tick();
        applyStimulus(1, 1, 0, 6'd2, 0);
        checkOutput("t5_abort_wrreq", 32'(fifo_wrreq), 32'd0);
        tick();
        applyStimulus(1, 0, 1, 6'd33, 0);
        checkOutput("t5_drop_cnt", 32'(drop_cnt), 32'd2);
        checkOutput("t5_last_data", 32'(fifo_data), 32'h86);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t5_pkt_cnt", 32'(pkt_cnt), 32'd3);
        expLog.push_back(8'h51); expLog.push_back(8'h55); expLog.push_back(8'h86);

        // Test 6: reset pulse mid-packet.
        applyStimulus(1, 1, 0, 6'd1, 0);
        tick();
        applyStimulus(1, 0, 0, 6'd4, 0);
        checkOutput("t6_b0_data", 32'(fifo_data), 32'h11);
        tick();
        expLog.push_back(8'h11);
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t6_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_rst_wrreq", 32'(fifo_wrreq), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_cnts", 32'(pkt_cnt | drop_cnt | trunc_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus(1, 0, 0, 6'd5, 0);
        checkOutput("t6_stray_wrreq", 32'(fifo_wrreq), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("t6_stray_busy", 32'(busy), 32'd0);
        checkOutput("t6_stray_cnts", 32'(pkt_cnt | drop_cnt | trunc_cnt), 32'd0);

        // Whole write history: count, order and content, and no write while full.
        checkOutput("log_size", 32'(wrLog.size()), 32'(expLog.size()));
        for (int i = 0; i < expLog.size(); i++) begin
            if (i < wrLog.size())
                checkOutput($sformatf("log_word%0d", i), 32'(wrLog[i]), 32'(expLog[i]));
        end
        checkOutput("write_while_full", 32'(fullWriteCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
